// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the CPU port (C)
// and the SPI readout engine (S). S may take a bounded burst lock so it can
// stream consecutive bytes; C still gets one slot every MAX_HOLD S grants.
// Read data comes back one cycle after the grant as a one-cycle rvalid pulse.
//
// state  | owner | meaning
// -------+-------+----------------------------------------------------------
// IDLE   | 00    | no access issued last cycle
// OWN_C  | 01    | last access belonged to C
// OWN_S  | 10    | last access belonged to S, no burst lock
// S_LOCK | 11    | S burst lock active; S wins contests until hold limit
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  s_req,
    input  logic                  s_lock,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    output logic                  s_gnt,
    output logic                  s_rvalid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [1:0]            owner
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic LAST_C = 1'b0;
    localparam logic LAST_S = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_C  = 2'b01,
        OWN_S  = 2'b10,
        S_LOCK = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic                  c_pend_q, c_pend_d;
    logic                  s_pend_q, s_pend_d;
    logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_d_q, mem_d_d;
    logic                  c_win, s_win;

    // Per-cycle winner; nothing is granted while reset is asserted.
    always_comb begin
        c_win = 1'b0;
        s_win = 1'b0;
        if (rst_n) begin
            if (c_req && !s_req) begin
                c_win = 1'b1;
            end else if (s_req && !c_req) begin
                s_win = 1'b1;
            end else if (c_req && s_req) begin
                if (state_q == S_LOCK) begin
                    if (hold_cnt_q < HOLD_LIMIT) s_win = 1'b1;
                    else                         c_win = 1'b1;
                end else if (last_q == LAST_C) begin
                    s_win = 1'b1;
                end else begin
                    c_win = 1'b1;
                end
            end
        end
    end

    // SRAM drive and requester-facing outputs.
    always_comb begin
        c_gnt    = c_win;
        s_gnt    = s_win;
        mem_cen  = !(c_win || s_win);
        mem_wen  = !(c_win && c_we);
        mem_addr = mem_addr_q;
        mem_d    = mem_d_q;
        if (c_win) begin
            mem_addr = c_addr;
            mem_d    = c_wdata;
        end else if (s_win) begin
            mem_addr = s_addr;
        end
        c_rvalid = c_pend_q;
        s_rvalid = s_pend_q;
        c_rdata  = c_pend_q ? mem_q : c_rdata_q;
        s_rdata  = s_pend_q ? mem_q : s_rdata_q;
        owner    = state_q;
    end

    // Next state, hold counter, round-robin pointer and read tracking.
    // A C grant while S holds the lock but is not requesting leaves the lock
    // in place: the lock only orders priority and must not be lost to an
    // opportunistic C access.
    always_comb begin
        state_d = state_q;
        if (s_win) begin
            state_d = s_lock ? S_LOCK : OWN_S;
        end else if (c_win) begin
            state_d = (state_q == S_LOCK && s_lock && !s_req) ? S_LOCK : OWN_C;
        end else begin
            state_d = (state_q == S_LOCK && s_lock) ? S_LOCK : IDLE;
        end

        hold_cnt_d = hold_cnt_q;
        if (c_win || !s_lock || state_d != S_LOCK) begin
            hold_cnt_d = '0;
        end else if (s_win && c_req && hold_cnt_q < HOLD_LIMIT) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end

        last_d = last_q;
        if (c_win)      last_d = LAST_C;
        else if (s_win) last_d = LAST_S;

        c_pend_d   = c_win && !c_we;
        s_pend_d   = s_win;
        c_rdata_d  = c_pend_q ? mem_q : c_rdata_q;
        s_rdata_d  = s_pend_q ? mem_q : s_rdata_q;
        mem_addr_d = mem_addr;
        mem_d_d    = mem_d;
    end

    // State registers; last resets to S so the first contested cycle goes to C.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= LAST_S;
            hold_cnt_q <= '0;
            c_pend_q   <= 1'b0;
            s_pend_q   <= 1'b0;
            c_rdata_q  <= '0;
            s_rdata_q  <= '0;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            c_pend_q   <= c_pend_d;
            s_pend_q   <= s_pend_d;
            c_rdata_q  <= c_rdata_d;
            s_rdata_q  <= s_rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_d_q    <= mem_d_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: SRAM device model, rule-level reference
// model, directed scenarios and a randomized run.
module tb_sram_port_arbiter;

    localparam int MAX_HOLD = 16;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       c_req, c_we, c_gnt, c_rvalid;
    logic [8:0] c_addr;
    logic [7:0] c_wdata, c_rdata;
    logic       s_req, s_lock, s_gnt, s_rvalid;
    logic [8:0] s_addr;
    logic [7:0] s_rdata;
    logic       mem_cen, mem_wen;
    logic [8:0] mem_addr;
    logic [7:0] mem_d, mem_q;
    logic [1:0] owner;

    sram_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .s_req(s_req), .s_lock(s_lock), .s_addr(s_addr),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_d(mem_d), .mem_q(mem_q), .owner(owner)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sram   [512];
    logic [7:0] shadow [512];

    // reference model state
    int         m_owner;
    bit         m_last_s;
    int         m_hold;
    bit         m_cp, m_sp;
    logic [7:0] m_cd, m_sd, m_crh, m_srh;
    logic [8:0] m_addr;
    int         e_win;
    logic       exp_c_gnt, exp_s_gnt, exp_cen, exp_wen, exp_c_rvalid, exp_s_rvalid;
    logic [8:0] exp_addr;
    logic [7:0] exp_c_rdata, exp_s_rdata;
    logic [1:0] exp_owner;

    task automatic model_reset();
        m_owner = 0; m_last_s = 1'b1; m_hold = 0;
        m_cp = 1'b0; m_sp = 1'b0;
        m_cd = 8'h00; m_sd = 8'h00; m_crh = 8'h00; m_srh = 8'h00;
        m_addr = 9'h000;
    endtask

    task automatic model_eval();
        e_win = 0;
        if (c_req && !s_req)      e_win = 1;
        else if (s_req && !c_req) e_win = 2;
        else if (c_req && s_req) begin
            if (m_owner == 3) e_win = (m_hold < MAX_HOLD) ? 2 : 1;
            else              e_win = m_last_s ? 1 : 2;
        end
        exp_c_gnt    = (e_win == 1);
        exp_s_gnt    = (e_win == 2);
        exp_cen      = (e_win == 0);
        exp_wen      = !(e_win == 1 && c_we);
        exp_addr     = (e_win == 1) ? c_addr : (e_win == 2) ? s_addr : m_addr;
        exp_c_rvalid = m_cp;
        exp_s_rvalid = m_sp;
        exp_c_rdata  = m_cp ? m_cd : m_crh;
        exp_s_rdata  = m_sp ? m_sd : m_srh;
        exp_owner    = 2'(m_owner);
    endtask

    task automatic model_commit();
        int nxt;
        if (m_cp) m_crh = m_cd;
        if (m_sp) m_srh = m_sd;
        m_cp = (e_win == 1) && !c_we;
        if (m_cp) m_cd = shadow[c_addr];
        m_sp = (e_win == 2);
        if (m_sp) m_sd = shadow[s_addr];
        if (e_win == 1 && c_we) shadow[c_addr] = c_wdata;
        if (e_win != 0) m_addr = exp_addr;
        if (e_win == 2)      nxt = s_lock ? 3 : 2;
        else if (e_win == 1) nxt = (m_owner == 3 && s_lock && !s_req) ? 3 : 1;
        else                 nxt = (m_owner == 3 && s_lock) ? 3 : 0;
        // consecutive S grants under lock while C is kept waiting
        if (e_win == 2 && s_lock && c_req) m_hold = (m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD;
        else if (e_win == 1 || !s_lock || nxt != 3) m_hold = 0;
        m_owner = nxt;
        if (e_win == 1)      m_last_s = 1'b0;
        else if (e_win == 2) m_last_s = 1'b1;
    endtask

    task automatic cycle_begin(input logic cr, input logic cw, input logic [8:0] ca,
                               input logic [7:0] cd, input logic sr, input logic sl,
                               input logic [8:0] sa);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        s_req = sr; s_lock = sl; s_addr = sa;
        #1;
        model_eval();
    endtask

    // advance one clock: SRAM device access, reference commit, back to negedge
    task automatic cycle_end();
        logic       cen_s, wen_s;
        logic [8:0] addr_s;
        logic [7:0] d_s;
        cen_s = mem_cen; wen_s = mem_wen; addr_s = mem_addr; d_s = mem_d;
        @(posedge CLK);
        model_commit();
        #1;
        if (!cen_s) begin
            if (!wen_s) sram[addr_s] = d_s;
            else        mem_q = sram[addr_s];
        end
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        s_req = 1'b0; s_lock = 1'b0; s_addr = '0;
        @(negedge CLK);
        @(negedge CLK);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h020; c_wdata = '0;
        s_req = 1'b1; s_lock = 1'b1; s_addr = 9'h000;
        @(negedge CLK); #1;
        n_tests++; if (owner !== 2'b00) begin n_fail++; $display("FAIL reset_owner got %b exp 00", owner); end
        n_tests++; if (c_gnt !== 1'b0 || s_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got c=%b s=%b exp 0/0", c_gnt, s_gnt); end
        n_tests++; if (mem_cen !== 1'b1 || mem_wen !== 1'b1) begin n_fail++; $display("FAIL reset_mem got cen=%b wen=%b exp 1/1", mem_cen, mem_wen); end
        n_tests++; if (c_rvalid !== 1'b0 || s_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got c=%b s=%b exp 0/0", c_rvalid, s_rvalid); end
        n_tests++; if (c_rdata !== 8'h00 || s_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got c=%h s=%h exp 00/00", c_rdata, s_rdata); end
        apply_reset();
        @(negedge CLK);
        cycle_begin(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (mem_cen !== 1'b1 || c_gnt !== 1'b0 || s_gnt !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got cen=%b c=%b s=%b exp 1/0/0", mem_cen, c_gnt, s_gnt); end
        cycle_end();
    endtask

    task automatic test_c_reads();
        for (int i = 0; i <= 14; i++) begin
            if (i < 14) cycle_begin(1, 0, 9'(9'h020 + i), 0, 0, 0, 0);
            else        cycle_begin(0, 0, 0, 0, 0, 0, 0);
            n_tests++; if (c_gnt !== exp_c_gnt) begin n_fail++; $display("FAIL creads_gnt i=%0d got %b exp %b", i, c_gnt, exp_c_gnt); end
            n_tests++; if (s_gnt !== 1'b0) begin n_fail++; $display("FAIL creads_sgnt i=%0d got %b exp 0", i, s_gnt); end
            n_tests++; if (c_rvalid !== (i > 0)) begin n_fail++; $display("FAIL creads_rvalid i=%0d got %b exp %b", i, c_rvalid, (i > 0)); end
            if (i > 0) begin
                n_tests++; if (c_rdata !== shadow[9'h020 + i - 1]) begin n_fail++; $display("FAIL creads_rdata i=%0d got %h exp %h", i, c_rdata, shadow[9'h020 + i - 1]); end
            end
            cycle_end();
        end
        cycle_begin(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (c_rvalid !== 1'b0 || c_rdata !== shadow[9'h02D]) begin n_fail++; $display("FAIL creads_hold got v=%b d=%h exp 0/%h", c_rvalid, c_rdata, shadow[9'h02D]); end
        cycle_end();
    endtask

    task automatic test_alternate();
        apply_reset();
        @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            cycle_begin(1, 0, 9'(9'h030 + i), 0, 1, 0, 9'(9'h040 + i));
            n_tests++; if (c_gnt !== (i % 2 == 0) || s_gnt !== (i % 2 == 1)) begin n_fail++; $display("FAIL alt_gnt i=%0d got c=%b s=%b exp c=%b", i, c_gnt, s_gnt, (i % 2 == 0)); end
            n_tests++; if (owner !== exp_owner) begin n_fail++; $display("FAIL alt_owner i=%0d got %b exp %b", i, owner, exp_owner); end
            if (i > 0) begin
                n_tests++; if (s_rvalid !== exp_s_rvalid || s_rdata !== exp_s_rdata || c_rdata !== exp_c_rdata) begin n_fail++; $display("FAIL alt_rdata i=%0d got s=%b/%h c=%h exp s=%b/%h c=%h", i, s_rvalid, s_rdata, c_rdata, exp_s_rvalid, exp_s_rdata, exp_c_rdata); end
            end
            cycle_end();
        end
        cycle_begin(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (owner !== 2'b10) begin n_fail++; $display("FAIL alt_owner_end got %b exp 10", owner); end
        cycle_end();
    endtask

    task automatic test_burst_lock();
        int         g [36];
        logic [7:0] sq [$];
        logic [8:0] sa;
        logic [7:0] want [4];
        want[0] = 8'hAB; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'h3C;
        apply_reset();
        @(negedge CLK);
        sa = 9'h000;
        for (int i = 0; i < 36; i++) begin
            cycle_begin(1, 0, 9'h050, 0, 1, 1, sa);
            g[i] = s_gnt ? 2 : (c_gnt ? 1 : 0);
            if (s_rvalid) sq.push_back(s_rdata);
            n_tests++; if (c_gnt !== exp_c_gnt || s_gnt !== exp_s_gnt || s_rdata !== exp_s_rdata || owner !== exp_owner) begin n_fail++; $display("FAIL lock_model i=%0d got c=%b s=%b d=%h o=%b exp c=%b s=%b d=%h o=%b", i, c_gnt, s_gnt, s_rdata, owner, exp_c_gnt, exp_s_gnt, exp_s_rdata, exp_owner); end
            if (s_gnt) sa = sa + 9'd1;
            cycle_end();
        end
        n_tests++; if (g[0] !== 1) begin n_fail++; $display("FAIL lock_first got %0d exp 1", g[0]); end
        for (int k = 0; k < 33; k++) begin
            n_tests++; if (g[1 + k] !== ((k == 16) ? 1 : 2)) begin n_fail++; $display("FAIL lock_seq k=%0d got %0d exp %0d", k, g[1 + k], (k == 16) ? 1 : 2); end
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (k >= sq.size()) begin n_fail++; $display("FAIL lock_rdata k=%0d got none exp %h", k, want[k]); end
            else if (sq[k] !== want[k]) begin n_fail++; $display("FAIL lock_rdata k=%0d got %h exp %h", k, sq[k], want[k]); end
        end
        cycle_begin(0, 0, 0, 0, 0, 0, 0);
        cycle_end();
    endtask

    task automatic test_write_then_read();
        cycle_begin(1, 1, 9'h010, 8'h5A, 0, 0, 0);
        n_tests++; if (mem_wen !== 1'b0 || mem_cen !== 1'b0 || mem_addr !== 9'h010 || mem_d !== 8'h5A) begin n_fail++; $display("FAIL wr_mem got cen=%b wen=%b a=%h d=%h exp 0/0/010/5a", mem_cen, mem_wen, mem_addr, mem_d); end
        cycle_end();
        cycle_begin(0, 0, 0, 0, 1, 0, 9'h010);
        n_tests++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid got %b exp 0", c_rvalid); end
        n_tests++; if (s_gnt !== 1'b1 || mem_wen !== 1'b1) begin n_fail++; $display("FAIL rd_issue got s=%b wen=%b exp 1/1", s_gnt, mem_wen); end
        cycle_end();
        cycle_begin(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (s_rvalid !== 1'b1 || s_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_data got v=%b d=%h exp 1/5a", s_rvalid, s_rdata); end
        n_tests++; if (mem_addr !== 9'h010) begin n_fail++; $display("FAIL addr_hold got %h exp 010", mem_addr); end
        cycle_end();
    endtask

    task automatic test_reset_mid();
        cycle_begin(0, 0, 0, 0, 1, 0, 9'h003);
        n_tests++; if (s_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b exp 1", s_gnt); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (mem_cen !== 1'b1 || s_gnt !== 1'b0 || owner !== 2'b00) begin n_fail++; $display("FAIL rstmid_out got cen=%b s=%b o=%b exp 1/0/00", mem_cen, s_gnt, owner); end
        @(posedge CLK); #1;
        n_tests++; if (s_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid got %b exp 0", s_rvalid); end
        @(negedge CLK);
        model_reset();
        rst_n = 1'b1;
        cycle_begin(1, 0, 9'h021, 0, 1, 0, 9'h004);
        n_tests++; if (c_gnt !== 1'b1 || s_gnt !== 1'b0) begin n_fail++; $display("FAIL rstmid_first got c=%b s=%b exp 1/0", c_gnt, s_gnt); end
        cycle_end();
        cycle_begin(0, 0, 0, 0, 0, 0, 0);
        cycle_end();
    endtask

    task automatic test_lock_idle();
        cycle_begin(0, 0, 0, 0, 1, 1, 9'h005);
        cycle_end();
        for (int i = 0; i < 3; i++) begin
            cycle_begin(0, 0, 0, 0, 0, 1, 0);
            n_tests++; if (owner !== 2'b11 || mem_cen !== 1'b1) begin n_fail++; $display("FAIL lockidle i=%0d got o=%b cen=%b exp 11/1", i, owner, mem_cen); end
            cycle_end();
        end
        cycle_begin(1, 0, 9'h022, 0, 0, 1, 0);
        n_tests++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL lockidle_cgnt got %b exp 1", c_gnt); end
        cycle_end();
        cycle_begin(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (owner !== 2'b11) begin n_fail++; $display("FAIL lockidle_kept got %b exp 11", owner); end
        n_tests++; if (c_rvalid !== 1'b1 || c_rdata !== shadow[9'h022]) begin n_fail++; $display("FAIL lockidle_rd got v=%b d=%h exp 1/%h", c_rvalid, c_rdata, shadow[9'h022]); end
        cycle_end();
        cycle_begin(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (owner !== 2'b00) begin n_fail++; $display("FAIL lockidle_release got %b exp 00", owner); end
        cycle_end();
    endtask

    task automatic test_random();
        logic lk;
        lk = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) lk = ~lk;
            cycle_begin(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 3) == 0),
                        9'($urandom_range(0, 63)), 8'($urandom),
                        1'($urandom_range(0, 9) < 7), lk, 9'($urandom_range(0, 63)));
            n_tests++; if (c_gnt !== exp_c_gnt || s_gnt !== exp_s_gnt) begin n_fail++; $display("FAIL rnd_gnt i=%0d got c=%b s=%b exp c=%b s=%b", i, c_gnt, s_gnt, exp_c_gnt, exp_s_gnt); end
            n_tests++; if (mem_cen !== exp_cen || mem_wen !== exp_wen || mem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_mem i=%0d got %b/%b/%h exp %b/%b/%h", i, mem_cen, mem_wen, mem_addr, exp_cen, exp_wen, exp_addr); end
            n_tests++; if (owner !== exp_owner) begin n_fail++; $display("FAIL rnd_owner i=%0d got %b exp %b", i, owner, exp_owner); end
            n_tests++; if (c_rvalid !== exp_c_rvalid || c_rdata !== exp_c_rdata) begin n_fail++; $display("FAIL rnd_c_rd i=%0d got %b/%h exp %b/%h", i, c_rvalid, c_rdata, exp_c_rvalid, exp_c_rdata); end
            n_tests++; if (s_rvalid !== exp_s_rvalid || s_rdata !== exp_s_rdata) begin n_fail++; $display("FAIL rnd_s_rd i=%0d got %b/%h exp %b/%h", i, s_rvalid, s_rdata, exp_s_rvalid, exp_s_rdata); end
            cycle_end();
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram[i]   = 8'($urandom);
            shadow[i] = sram[i];
        end
        sram[0] = 8'hAB; sram[1] = 8'h00; sram[2] = 8'h00; sram[3] = 8'h3C;
        for (int i = 0; i < 4; i++) shadow[i] = sram[i];
        mem_q = 8'h00;
        model_reset();
        test_reset();
        test_c_reads();
        test_alternate();
        test_burst_lock();
        test_write_then_read();
        test_reset_mid();
        test_lock_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
